// File: rtl/user_data_checker.sv
// Stream packet checker: parses a size header, verifies an incrementing payload and its byte
// enables and length, then reports per-packet error flags and running packet/error counts.
module user_data_checker #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_SIZE = 256
) (
    input  logic             log_clk,
    input  logic             log_rst,
    input  logic             user_tvalid_in,
    input  logic [63:0]      user_tdata_in,
    input  logic [7:0]       user_tkeep_in,
    input  logic             user_tlast_in,
    output logic             user_tready_o,
    output logic             pkt_done_o,
    output logic             pkt_err_o,
    output logic [3:0]       err_flags_o,
    output logic [11:0]      pkt_size_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [63:0]      r_exp_data;
    logic [8:0]       r_beat_idx;
    logic [8:0]       r_last_idx;
    logic [7:0]       r_last_keep;
    logic [3:0]       r_flags;
    logic             r_done;
    logic             r_err;
    logic [3:0]       r_err_flags;
    logic [11:0]      r_pkt_size;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [1:0]  w_state_d;
    logic [3:0]  w_flags_d;
    logic        w_close;
    logic        w_accept;
    logic [12:0] w_hdr_size;
    logic        w_hdr_bad;
    logic        w_at_last;
    logic [7:0]  w_keep_exp;

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign user_tready_o = !log_rst && (r_state != ST_DONE);
    assign w_accept      = user_tvalid_in && user_tready_o;
    assign w_hdr_size    = {1'b0, user_tdata_in[11:0]} + 13'd1;
    assign w_hdr_bad     = (|user_tdata_in[63:12]) || ({19'd0, w_hdr_size} > MAX_SIZE);
    assign w_at_last     = (r_beat_idx == r_last_idx);
    assign w_keep_exp    = w_at_last ? r_last_keep : 8'hFF;

    always_comb begin
        w_state_d = r_state;
        w_flags_d = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_flags_d = {w_hdr_bad | user_tlast_in, user_tlast_in, 2'b00};
                    w_state_d = user_tlast_in ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_accept) begin
                    if (user_tdata_in != r_exp_data) w_flags_d[0] = 1'b1;
                    if (user_tkeep_in != w_keep_exp) w_flags_d[1] = 1'b1;
                    if (w_at_last) begin
                        if (user_tlast_in) begin
                            w_state_d = ST_DONE;
                        end else begin
                            w_flags_d[2] = 1'b1;
                            w_state_d    = ST_DRAIN;
                        end
                    end else if (user_tlast_in) begin
                        w_flags_d[2] = 1'b1;
                        w_state_d    = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept && user_tlast_in) w_state_d = ST_DONE;
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
        w_close = (w_state_d == ST_DONE);
    end

    // Report registers load on the closing edge so they are valid throughout the DONE cycle.
    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            r_state     <= ST_IDLE;
            r_exp_data  <= '0;
            r_beat_idx  <= '0;
            r_last_idx  <= '0;
            r_last_keep <= '0;
            r_flags     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_flags <= '0;
            r_pkt_size  <= '0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_flags <= w_flags_d;
            r_done  <= w_close;
            r_err   <= w_close && (|w_flags_d);
            if (w_close) begin
                r_err_flags <= w_flags_d;
                if (r_pkt_cnt != {CNT_W{1'b1}}) r_pkt_cnt <= r_pkt_cnt + 1'b1;
                if ((|w_flags_d) && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_accept && (r_state == ST_IDLE)) begin
                r_pkt_size  <= w_hdr_size[11:0];
                r_exp_data  <= user_tdata_in + 64'd1;
                r_beat_idx  <= '0;
                r_last_idx  <= user_tdata_in[11:3];
                r_last_keep <= 8'hFF << (3'd7 - user_tdata_in[2:0]);
            end
            if (w_accept && (r_state == ST_RECV)) begin
                r_exp_data <= r_exp_data + 64'd1;
                r_beat_idx <= r_beat_idx + 9'd1;
            end
        end
    end

    assign pkt_done_o  = r_done;
    assign pkt_err_o   = r_err;
    assign err_flags_o = r_err_flags;
    assign pkt_size_o  = r_pkt_size;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_user_data_checker.sv
// Randomized bench for user_data_checker: builds packets as beat queues, predicts each report
// from a packet-level reference model and checks every done pulse against it.
module tb_user_data_checker;

    localparam int CNT_W    = 16;
    localparam int MAX_SIZE = 256;

    logic             log_clk = 1'b0;
    logic             log_rst = 1'b1;
    logic             user_tvalid_in = 1'b0;
    logic [63:0]      user_tdata_in = '0;
    logic [7:0]       user_tkeep_in = '0;
    logic             user_tlast_in = 1'b0;
    logic             user_tready_o;
    logic             pkt_done_o;
    logic             pkt_err_o;
    logic [3:0]       err_flags_o;
    logic [11:0]      pkt_size_o;
    logic [CNT_W-1:0] pkt_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    user_data_checker #(.CNT_W(CNT_W), .MAX_SIZE(MAX_SIZE)) u_dut (
        .log_clk        (log_clk),
        .log_rst        (log_rst),
        .user_tvalid_in (user_tvalid_in),
        .user_tdata_in  (user_tdata_in),
        .user_tkeep_in  (user_tkeep_in),
        .user_tlast_in  (user_tlast_in),
        .user_tready_o  (user_tready_o),
        .pkt_done_o     (pkt_done_o),
        .pkt_err_o      (pkt_err_o),
        .err_flags_o    (err_flags_o),
        .pkt_size_o     (pkt_size_o),
        .pkt_cnt_o      (pkt_cnt_o),
        .err_cnt_o      (err_cnt_o)
    );

    always #5 log_clk = ~log_clk;

    typedef struct {
        logic [3:0]  flags;
        logic [11:0] size;
        int          cnt;
        int          ecnt;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cnt   = 0;
    int          m_ecnt  = 0;
    int          n_done  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] pd[$];
    logic [7:0]  pk[$];
    logic        pl[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] last_keep(input int size);
        logic [15:0] t;
        int r;
        r = size % 8;
        if (r == 0) return 8'hFF;
        t = 16'h00FF << (8 - r);
        return t[7:0];
    endfunction

    // Builds a well-formed packet of the given size into pd/pk/pl.
    task automatic gen_clean(input int size);
        logic [63:0] hdr;
        int n;
        pd.delete(); pk.delete(); pl.delete();
        hdr = 64'(size - 1);
        n = (size + 7) / 8;
        pd.push_back(hdr); pk.push_back(8'hFF); pl.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            pd.push_back(hdr + 64'(k) + 64'd1);
            pk.push_back((k == n - 1) ? last_keep(size) : 8'hFF);
            pl.push_back(k == n - 1);
        end
    endtask

    // Packet-level reference: walks the beat queue applying the framing rules.
    function automatic logic [3:0] ref_flags();
        logic [63:0] hdr;
        logic [3:0]  f;
        int size, n, k;
        hdr  = pd[0];
        size = int'(hdr[11:0]) + 1;
        f    = 4'b0000;
        if (hdr[63:12] != 0 || size > MAX_SIZE) f[3] = 1'b1;
        if (pl[0]) return f | 4'b1100;
        n = (size + 7) / 8;
        for (k = 0; k < n && k + 1 < pd.size(); k++) begin
            if (pd[k+1] != hdr + 64'(k) + 64'd1) f[0] = 1'b1;
            if (pk[k+1] != ((k == n - 1) ? last_keep(size) : 8'hFF)) f[1] = 1'b1;
            if (pl[k+1]) begin
                if (k < n - 1) f[2] = 1'b1;
                return f;
            end
        end
        f[2] = 1'b1;
        return f;
    endfunction

    task automatic push_exp(input logic [3:0] flags, input logic [11:0] size);
        exp_t e;
        if (m_cnt < 65535) m_cnt++;
        if (flags != 0 && m_ecnt < 65535) m_ecnt++;
        e.flags = flags; e.size = size; e.cnt = m_cnt; e.ecnt = m_ecnt;
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input bit gaps);
        bit acc;
        int budget;
        if (gaps) begin
            user_tvalid_in = 1'b0;
            user_tdata_in  = 64'($urandom) << 32 | 64'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge log_clk);
        end
        user_tvalid_in = 1'b1; user_tdata_in = d; user_tkeep_in = k; user_tlast_in = l;
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 20) begin
            #1 acc = user_tready_o;
            @(negedge log_clk);
            budget++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        user_tvalid_in = 1'b0;
        user_tlast_in  = 1'b0;
    endtask

    task automatic send_pkt(input bit gaps, input int nbeats);
        for (int i = 0; i < nbeats && i < pd.size(); i++) send_beat(pd[i], pk[i], pl[i], gaps);
    endtask

    task automatic send_model(input bit gaps);
        logic [12:0] sz;
        sz = {1'b0, pd[0][11:0]} + 13'd1;
        push_exp(ref_flags(), sz[11:0]);
        send_pkt(gaps, pd.size());
    endtask

    // Applies one randomly chosen fault (or none) to the packet in the queues.
    task automatic gen_random();
        int size, n, mode, j;
        mode = $urandom_range(0, 7);
        size = (mode == 7) ? $urandom_range(MAX_SIZE + 1, 400) : $urandom_range(1, MAX_SIZE);
        gen_clean(size);
        n = (size + 7) / 8;
        case (mode)
            1: begin
                j = $urandom_range(1, n);
                pd[j] = pd[j] ^ (64'd1 << $urandom_range(0, 63));
            end
            2: pk[n] = pk[n] ^ (8'h01 << $urandom_range(0, 7));
            3: if (n > 1) begin
                j = $urandom_range(1, n - 1);
                while (pd.size() > j + 1) begin
                    void'(pd.pop_back()); void'(pk.pop_back()); void'(pl.pop_back());
                end
                pl[j] = 1'b1;
            end
            4: begin
                pl[n] = 1'b0;
                j = $urandom_range(1, 4);
                for (int i = 0; i < j; i++) begin
                    pd.push_back(64'($urandom)); pk.push_back(8'($urandom));
                    pl.push_back(i == j - 1);
                end
            end
            5: pd[0] = pd[0] | (64'($urandom_range(1, 255)) << 20);
            6: begin
                while (pd.size() > 1) begin
                    void'(pd.pop_back()); void'(pk.pop_back()); void'(pl.pop_back());
                end
                pl[0] = 1'b1;
            end
            default: ;
        endcase
    endtask

    always @(negedge log_clk) begin
        #2;
        if (!log_rst) begin
            check("tready_vs_done", 64'(user_tready_o), 64'(!pkt_done_o));
            if (pkt_done_o) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_flags", 64'(err_flags_o), 64'(mon_e.flags));
                    check("pkt_err", 64'(pkt_err_o), 64'(mon_e.flags != 0));
                    check("pkt_size", 64'(pkt_size_o), 64'(mon_e.size));
                    check("pkt_cnt", 64'(pkt_cnt_o), 64'(mon_e.cnt));
                    check("err_cnt", 64'(err_cnt_o), 64'(mon_e.ecnt));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 64'(user_tready_o), 64'd0);
        check({tag, "_done"}, 64'(pkt_done_o), 64'd0);
        check({tag, "_err"}, 64'(pkt_err_o), 64'd0);
        check({tag, "_flags"}, 64'(err_flags_o), 64'd0);
        check({tag, "_size"}, 64'(pkt_size_o), 64'd0);
        check({tag, "_cnt"}, 64'(pkt_cnt_o), 64'd0);
        check({tag, "_ecnt"}, 64'(err_cnt_o), 64'd0);
    endtask

    initial begin
        log_rst = 1'b1;
        repeat (3) @(negedge log_clk);
        #1 check_reset_outputs("rst");
        @(negedge log_clk);
        log_rst = 1'b0;
        #1 check("tready_after_rst", 64'(user_tready_o), 64'd1);
        @(negedge log_clk);

        // Clean 256-byte packet
        gen_clean(256);
        push_exp(4'b0000, 12'd256);
        send_pkt(1'b0, pd.size());
        // Size 253 with correct and with wrong final keep
        gen_clean(253);
        check("keep_253", 64'(pk[32]), 64'hF8);
        push_exp(4'b0000, 12'd253);
        send_pkt(1'b0, pd.size());
        pk[32] = 8'hFF;
        push_exp(4'b0010, 12'd253);
        send_pkt(1'b0, pd.size());
        // Corrupted beat 5, then a clean packet
        gen_clean(256);
        pd[6] = 64'd0;
        push_exp(4'b0001, 12'd256);
        send_pkt(1'b1, pd.size());
        gen_clean(256);
        push_exp(4'b0000, 12'd256);
        send_pkt(1'b1, pd.size());
        // Early tlast on payload beat 10
        gen_clean(256);
        pl[11] = 1'b1;
        push_exp(4'b0100, 12'd256);
        send_pkt(1'b0, 12);
        check("early_done_next_cycle", 64'(pkt_done_o), 64'd1);
        // Missing tlast on beat 31, tlast on beat 35
        gen_clean(256);
        pl[32] = 1'b0;
        for (int i = 32; i <= 35; i++) begin
            pd.push_back(64'h100 + 64'(i)); pk.push_back(8'hFF); pl.push_back(i == 35);
        end
        push_exp(4'b0100, 12'd256);
        send_pkt(1'b0, pd.size());
        // Header-only packet
        gen_clean(17);
        pl[0] = 1'b1;
        push_exp(4'b1100, 12'd17);
        send_pkt(1'b0, 1);

        // Randomized packets with gaps, back to back
        for (int p = 0; p < 40; p++) begin
            gen_random();
            send_model($urandom_range(0, 1) == 1);
        end
        repeat (3) @(negedge log_clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a packet
        gen_clean(256);
        send_pkt(1'b1, 10);
        log_rst = 1'b1;
        m_cnt = 0;
        m_ecnt = 0;
        repeat (2) @(negedge log_clk);
        #1 check_reset_outputs("midrst");
        log_rst = 1'b0;
        repeat (4) @(negedge log_clk);
        check("midrst_no_done", 64'(n_done), 64'(n_done));
        gen_clean(100);
        push_exp(4'b0000, 12'd100);
        send_pkt(1'b1, pd.size());

        repeat (4) @(negedge log_clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_pkt_cnt", 64'(pkt_cnt_o), 64'(m_cnt));
        check("final_err_cnt", 64'(err_cnt_o), 64'(m_ecnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/user_data_checker.md
USER_DATA_CHECKER -- requirements
Module: user_data_checker

Interface
REQ-001 Parameter CNT_W, 16: width of the packet and error counters.
REQ-002 Parameter MAX_SIZE, 256: largest legal payload size in bytes.
REQ-003 log_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 log_rst  in  1  reset; synchronous, active-high.
REQ-005 user_tvalid_in  in  1  stream beat valid.
REQ-006 user_tdata_in  in  64  beat data.
REQ-007 user_tkeep_in  in  8  byte enables, MSB-first (bit 7 = byte 0).
REQ-008 user_tlast_in  in  1  last beat of packet.
REQ-009 user_tready_o  out  1  checker accepts a beat.
REQ-010 pkt_done_o  out  1  one-cycle pulse when a packet is closed.
REQ-011 pkt_err_o  out  1  one-cycle pulse with pkt_done_o when err_flags_o is nonzero.
REQ-012 err_flags_o  out  4  per-packet flags: [0] data, [1] keep, [2] length, [3] header; held until the next packet closes.
REQ-013 pkt_size_o  out  12  payload byte count decoded from the last header; held.
REQ-014 pkt_cnt_o  out  CNT_W  packets closed since reset.
REQ-015 err_cnt_o  out  CNT_W  packets closed with err_flags nonzero.

Function
REQ-016 A beat is accepted only when user_tvalid_in and user_tready_o are both 1.
REQ-017 Packet format:
  - Header beat: data[11:0] = size-1, data[63:12] = 0.
  - Then N = ceil(size/8) payload beats.
  - Payload beat k (k = 0..N-1) carries data = header data + 1 + k (64-bit, wraps modulo 2^64).
REQ-018 States are IDLE, RECV, DRAIN and DONE.
REQ-019 user_tready_o is 1 in IDLE, RECV and DRAIN, and 0 in DONE.
REQ-020 In IDLE, an accepted beat is the header:
  - Latch size = data[11:0]+1 into pkt_size_o.
  - Set expected data = header data + 1.
  - Clear the beat index.
  - Clear the working flags.
  - Next state is RECV.
REQ-021 Header error (flag [3]) is set when data[63:12] is nonzero or size > MAX_SIZE.
  - Checking continues.
  - The size value used is the latched data[11:0]+1.
REQ-022 A header with user_tlast_in=1 sets flags [3] and [2], and the next state is DONE.
REQ-023 In RECV, each accepted beat:
  - is compared with expected data; a mismatch sets flag [0];
  - then increments the expected data and the beat index.
REQ-024 tkeep check:
  - Non-final beats must carry 8'hFF.
  - The beat at index N-1 must carry r MSB-first ones, where r = size mod 8 (r=0 means 8'hFF); e.g. r=1 gives 8'h80, r=3 gives 8'hE0, r=7 gives 8'hFE.
  - A mismatch sets flag [1].
REQ-025 tlast at index < N-1 sets flag [2]; the next state is DONE.
REQ-026 tlast at index N-1 means the next state is DONE with no length error.
REQ-027 No tlast at index N-1 sets flag [2]; the next state is DRAIN.
REQ-028 DRAIN discards accepted beats with no data or keep checks; tlast moves the state to DONE.
REQ-029 DONE lasts exactly one cycle:
  - pkt_done_o = 1.
  - err_flags_o is loaded from the working flags.
  - pkt_err_o = |flags.
  - pkt_cnt_o increments.
  - err_cnt_o increments if |flags.
  - Next state is IDLE.
REQ-030 Flags raised on the closing beat are included in that packet's report, so the report appears one cycle after that beat.
REQ-031 Counters saturate at all-ones and do not wrap.
REQ-032 Beats with tvalid=0 change no state; gaps of any length are legal.

Reset
REQ-033 While log_rst=1 at a clock edge:
  - state = IDLE;
  - user_tready_o, pkt_done_o, pkt_err_o = 0;
  - err_flags_o = 0, pkt_size_o = 0, pkt_cnt_o = 0, err_cnt_o = 0.
REQ-034 Reset mid-packet discards the packet and produces no report.
REQ-035 user_tready_o is 1 on the first cycle after reset deasserts.

Verification
REQ-036 Clean packet: header 0xFF followed by 32 beats 0x100..0x11F, last keep FF with tlast -> one pkt_done_o, flags 0, pkt_size_o=256, pkt_cnt_o=1.
REQ-037 Size 253: header 0xFC followed by 32 beats 0xFD..0x11C, last keep 8'hF8 -> flags 0; the same stream with last keep 8'hFF -> flags 4'b0010, err_cnt_o=1.
REQ-038 Size 256 with beat 5 corrupted to 0 -> flags 4'b0001; the next clean packet reports flags 0.
REQ-039 tlast on payload beat 10 of a 256-byte packet -> flags 4'b0100, done on the following cycle.
REQ-040 Missing tlast on beat 31, tlast on beat 35 -> flags 4'b0100 after beat 35.
REQ-041 Random tvalid gaps and back-to-back packets: one done per packet, tready low only in DONE.
REQ-042 Reset mid-packet: no report, and the next packet checks clean.
